// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: zero-cycle Mealy enables/bubbles, memory-wait watchdog into sticky HALT.
// Optional performance counters (stall_cycles, flush_count) are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             exmem_memreq,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NORMAL  = 2'd0,
    SEL_FLUSH   = 2'd1,
    SEL_LOADUSE = 2'd2,
    SEL_FREEZE  = 2'd3
  } sel_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic miss;
  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic frozen;
  sel_e sel;

  assign miss     = exmem_memreq & ~mem_ready;
  assign rs_hit   = ifid_uses_rs & (idex_rt == ifid_rs);
  assign rt_hit   = ifid_uses_rt & (idex_rt == ifid_rt);
  assign load_use = idex_memread & (idex_rt != 5'd0) & (rs_hit | rt_hit);

  // Hazards are only acted on when the pipeline actually moves; while frozen the
  // upstream registers hold, so the same hazard is re-seen on the release cycle.
  assign frozen = (state_q == ST_HALT) | miss | ((state_q == ST_MEMWAIT) & ~mem_ready);

  always_comb begin
    sel = SEL_NORMAL;
    if (frozen) begin
      sel = SEL_FREEZE;
    end else if (branch_taken) begin
      sel = SEL_FLUSH;
    end else if (load_use) begin
      sel = SEL_LOADUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (miss) begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (sel)
        SEL_FREEZE: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
        end
        SEL_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        SEL_LOADUSE: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (((sel == SEL_FREEZE) || (sel == SEL_LOADUSE)) && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if ((sel == SEL_FLUSH) && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded random/directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idex_memread;
  logic [4:0]    idex_rt, ifid_rs, ifid_rt;
  logic          ifid_uses_rs, ifid_uses_rt;
  logic          branch_taken, exmem_memreq, mem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .exmem_memreq(exmem_memreq), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] C_NORMAL  = 7'b1111_000;
  localparam logic [6:0] C_FREEZE  = 7'b0000_001;
  localparam logic [6:0] C_FLUSH   = 7'b1111_110;
  localparam logic [6:0] C_LOADUSE = 7'b0011_010;
  localparam logic [6:0] C_RESET   = 7'b0000_111;

  typedef struct packed {
    logic [6:0]    ctl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: a miss episode is a run of consecutive frozen cycles;
  // the watchdog trips after MEM_TIMEOUT+1 of them.
  bit m_wait, m_halt, m_err;
  int m_nfreeze, m_stall, m_flush;

  task automatic model_clear();
    m_wait = 0; m_halt = 0; m_err = 0; m_nfreeze = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input logic rn, input logic mrd, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic br, input logic mreq, input logic mrdy);
    exp_t e;
    bit   lu, frz;
    @(posedge clk);
    #1;
    rst_n = rn; idex_memread = mrd; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
    ifid_uses_rs = urs; ifid_uses_rt = urt; branch_taken = br;
    exmem_memreq = mreq; mem_ready = mrdy;

    lu  = mrd && (xrt != 0) && ((urs && xrt == rs) || (urt && xrt == rt));
    frz = m_halt || (mreq && !mrdy) || (m_wait && !mrdy);
    if (!rn)      e.ctl = C_RESET;
    else if (frz) e.ctl = C_FREEZE;
    else if (br)  e.ctl = C_FLUSH;
    else if (lu)  e.ctl = C_LOADUSE;
    else          e.ctl = C_NORMAL;
    e.err   = m_err;
`ifdef HAZARD_PERF_EN
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    exp_q.push_back(e);

    if (!rn) begin
      model_clear();
    end else begin
      if (frz || (!br && lu)) m_stall = (m_stall < (2**CW - 1)) ? m_stall + 1 : m_stall;
      if (!frz && br)         m_flush = (m_flush < (2**CW - 1)) ? m_flush + 1 : m_flush;
      if (!m_halt) begin
        if (frz) begin
          m_wait    = 1;
          m_nfreeze = m_nfreeze + 1;
          if (m_nfreeze == TO + 1) begin
            m_halt = 1;
            m_err  = 1;
          end
        end else begin
          m_wait    = 0;
          m_nfreeze = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s sample=%0d got=%0h expected=%0h", name, idx, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  initial begin : monitor
    int   idx;
    exp_t e;
    idx = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl", idx, 32'({pc_write, ifid_write, idex_write, exmem_write,
                            ifid_flush, idex_bubble, memwb_bubble}), 32'(e.ctl));
        chk("mem_err", idx, 32'(mem_err), 32'(e.err));
        chk("stall_cycles", idx, 32'(stall_cycles), 32'(e.stall));
        chk("flush_count", idx, 32'(flush_count), 32'(e.flush));
        idx = idx + 1;
      end
    end
  end

  initial begin : stim
    logic       rn, mrd, urs, urt, br, mreq, mrdy;
    logic [4:0] xrt, rs, rt;
    rst_n = 1'b0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rs = 0; ifid_uses_rt = 0; branch_taken = 0; exmem_memreq = 0; mem_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);

    // reset, load-use, rt=0, load-use overridden by branch
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    step(1, 0, 5, 5, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 5, 5, 0, 1, 0, 1, 0, 0);
    step(1, 0, 9, 0, 9, 0, 1, 0, 0, 0);
    step(1, 1, 9, 0, 9, 0, 1, 0, 0, 0);
    // three-cycle miss then release
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // watchdog: held-low ready trips HALT, stays frozen, reset clears
    repeat (6) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // miss with branch: frozen, then flush on release
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // reset while waiting: no residual stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rn   = ($urandom_range(0, 99) >= 2);
      mrd  = 1'($urandom_range(0, 1));
      xrt  = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      urs  = 1'($urandom_range(0, 1));
      urt  = 1'($urandom_range(0, 1));
      br   = ($urandom_range(0, 99) < 20);
      mreq = m_wait ? 1'b1 : ($urandom_range(0, 99) < 25);
      mrdy = m_wait ? ($urandom_range(0, 99) < 40) : 1'($urandom_range(0, 1));
      step(rn, mrd, xrt, rs, rt, urs, urt, br, mreq, mrdy);
    end

    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
